// File: rtl/phy_pkg.sv
// Shared widths, FSM encoding and beat payload for the PHY transmit path.
package phy_pkg;

   localparam int unsigned AXIS_DATA_W = 64;
   localparam int unsigned AXIS_KEEP_W = 8;
   localparam int unsigned AXIS_BEAT_W = AXIS_DATA_W + AXIS_KEEP_W + 1;

   typedef enum logic {
      ST_IDLE = 1'b0,
      ST_PKT  = 1'b1
   } arb_state_e;

   typedef struct packed {
      logic [AXIS_DATA_W-1:0] data;
      logic [AXIS_KEEP_W-1:0] keep;
      logic                   last;
   } axis_beat_t;

endpackage

// File: rtl/phy_axis_skid.sv
// Two-entry register slice: registered payload and valid downstream, registered ready upstream,
// full throughput while the sink is ready.
module phy_axis_skid
   import phy_pkg::*;
#(
   parameter int unsigned WIDTH = AXIS_BEAT_W
) (
   input  logic             i_clk,
   input  logic             i_rst_n,
   input  logic             s_valid,
   output logic             s_ready,
   input  logic [WIDTH-1:0] s_payload,
   output logic             m_valid,
   input  logic             m_ready,
   output logic [WIDTH-1:0] m_payload
);

   logic             skid_valid;
   logic [WIDTH-1:0] skid_payload;
   logic             accept;
   logic             pop;

   assign accept = s_valid & s_ready;
   assign pop    = m_valid & m_ready;

   // s_ready mirrors !skid_valid, so a beat never arrives while the skid entry is occupied
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         m_valid      <= 1'b0;
         m_payload    <= '0;
         skid_valid   <= 1'b0;
         skid_payload <= '0;
         s_ready      <= 1'b1;
      end else if (!m_valid || pop) begin
         if (skid_valid) begin
            m_valid    <= 1'b1;
            m_payload  <= skid_payload;
            skid_valid <= 1'b0;
            s_ready    <= 1'b1;
         end else begin
            m_valid <= accept;
            if (accept) begin
               m_payload <= s_payload;
            end
         end
      end else if (accept) begin
         skid_valid   <= 1'b1;
         skid_payload <= s_payload;
         s_ready      <= 1'b0;
      end
   end

endmodule

// File: rtl/phy_tx_arbiter.sv
// Packet-granular round-robin arbiter sharing the PHY transmit AXI-Stream port between
// REQ_NUM requesters; grants only while the link is up, output through a skid slice.
module phy_tx_arbiter
   import phy_pkg::*;
#(
   parameter int unsigned REQ_NUM = 4
) (
   input  logic                           i_clk,
   input  logic                           i_rst_n,
   input  logic                           i_link_up,
   input  logic [AXIS_DATA_W*REQ_NUM-1:0] s_axis_data,
   input  logic [AXIS_KEEP_W*REQ_NUM-1:0] s_axis_keep,
   input  logic [REQ_NUM-1:0]             s_axis_last,
   input  logic [REQ_NUM-1:0]             s_axis_valid,
   output logic [REQ_NUM-1:0]             s_axis_ready,
   output logic [AXIS_DATA_W-1:0]         m_axis_data,
   output logic [AXIS_KEEP_W-1:0]         m_axis_keep,
   output logic                           m_axis_last,
   output logic                           m_axis_valid,
   input  logic                           m_axis_ready,
   output logic [REQ_NUM-1:0]             o_grant,
   output logic                           o_busy
);

   localparam int unsigned IDX_W = (REQ_NUM > 1) ? $clog2(REQ_NUM) : 1;

   arb_state_e         state_q, state_d;
   logic [REQ_NUM-1:0] grant_q, grant_d;
   logic [IDX_W-1:0]   gidx_q, gidx_d;
   logic [IDX_W-1:0]   rr_ptr_q, rr_ptr_d;
   logic [IDX_W-1:0]   pick_idx;
   logic               pick_found;
   axis_beat_t         sel_beat;
   axis_beat_t         out_beat;
   logic               sel_valid;
   logic               sk_s_valid;
   logic               sk_s_ready;
   logic               beat_acc;

   // Two-pass pick: lowest valid index above rr_ptr, else lowest valid index overall
   always_comb begin
      pick_idx   = '0;
      pick_found = |s_axis_valid;
      for (int i = REQ_NUM - 1; i >= 0; i--) begin
         if (s_axis_valid[i]) begin
            pick_idx = IDX_W'(i);
         end
      end
      for (int i = REQ_NUM - 1; i >= 0; i--) begin
         if (s_axis_valid[i] && (IDX_W'(i) > rr_ptr_q)) begin
            pick_idx = IDX_W'(i);
         end
      end
   end

   // One-hot grant mux of the granted requester's beat
   always_comb begin
      sel_beat  = '0;
      sel_valid = 1'b0;
      for (int k = 0; k < REQ_NUM; k++) begin
         if (grant_q[k]) begin
            sel_beat.data = s_axis_data[k*AXIS_DATA_W +: AXIS_DATA_W];
            sel_beat.keep = s_axis_keep[k*AXIS_KEEP_W +: AXIS_KEEP_W];
            sel_beat.last = s_axis_last[k];
            sel_valid     = s_axis_valid[k];
         end
      end
   end

   assign sk_s_valid   = (state_q == ST_PKT) & sel_valid;
   assign beat_acc     = sk_s_valid & sk_s_ready;
   assign s_axis_ready = grant_q & {REQ_NUM{sk_s_ready}};

   always_comb begin
      state_d  = state_q;
      grant_d  = grant_q;
      gidx_d   = gidx_q;
      rr_ptr_d = rr_ptr_q;
      case (state_q)
         ST_IDLE: begin
            if (i_link_up && pick_found) begin
               state_d = ST_PKT;
               grant_d = REQ_NUM'(1) << pick_idx;
               gidx_d  = pick_idx;
            end
         end
         ST_PKT: begin
            if (beat_acc && sel_beat.last) begin
               state_d  = ST_IDLE;
               grant_d  = '0;
               rr_ptr_d = gidx_q;
            end
         end
      endcase
   end

   // rr_ptr resets to the last index so requester 0 wins the first arbitration
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         state_q  <= ST_IDLE;
         grant_q  <= '0;
         gidx_q   <= '0;
         rr_ptr_q <= IDX_W'(REQ_NUM - 1);
      end else begin
         state_q  <= state_d;
         grant_q  <= grant_d;
         gidx_q   <= gidx_d;
         rr_ptr_q <= rr_ptr_d;
      end
   end

   phy_axis_skid #(
      .WIDTH (AXIS_BEAT_W)
   ) u_skid (
      .i_clk     (i_clk),
      .i_rst_n   (i_rst_n),
      .s_valid   (sk_s_valid),
      .s_ready   (sk_s_ready),
      .s_payload (sel_beat),
      .m_valid   (m_axis_valid),
      .m_ready   (m_axis_ready),
      .m_payload (out_beat)
   );

   assign m_axis_data = out_beat.data;
   assign m_axis_keep = out_beat.keep;
   assign m_axis_last = out_beat.last;
   assign o_grant     = grant_q;
   assign o_busy      = (state_q == ST_PKT);

endmodule

// File: tb/tb_phy_tx_arbiter.sv
// Bench for phy_tx_arbiter: queued packet sources, a round-robin grant model and an
// in-order output scoreboard, plus directed scenario tasks and a randomized soak.
module tb_phy_tx_arbiter;
   import phy_pkg::*;

   localparam int unsigned REQ_NUM = 4;
   localparam int unsigned DW = AXIS_DATA_W;
   localparam int unsigned KW = AXIS_KEEP_W;

   logic                   i_clk = 1'b0;
   logic                   i_rst_n;
   logic                   i_link_up;
   logic [DW*REQ_NUM-1:0]  s_axis_data;
   logic [KW*REQ_NUM-1:0]  s_axis_keep;
   logic [REQ_NUM-1:0]     s_axis_last;
   logic [REQ_NUM-1:0]     s_axis_valid;
   logic [REQ_NUM-1:0]     s_axis_ready;
   logic [DW-1:0]          m_axis_data;
   logic [KW-1:0]          m_axis_keep;
   logic                   m_axis_last;
   logic                   m_axis_valid;
   logic                   m_axis_ready;
   logic [REQ_NUM-1:0]     o_grant;
   logic                   o_busy;

   always #5 i_clk = ~i_clk;

   phy_tx_arbiter #(.REQ_NUM(REQ_NUM)) dut (
      .i_clk        (i_clk),
      .i_rst_n      (i_rst_n),
      .i_link_up    (i_link_up),
      .s_axis_data  (s_axis_data),
      .s_axis_keep  (s_axis_keep),
      .s_axis_last  (s_axis_last),
      .s_axis_valid (s_axis_valid),
      .s_axis_ready (s_axis_ready),
      .m_axis_data  (m_axis_data),
      .m_axis_keep  (m_axis_keep),
      .m_axis_last  (m_axis_last),
      .m_axis_valid (m_axis_valid),
      .m_axis_ready (m_axis_ready),
      .o_grant      (o_grant),
      .o_busy       (o_busy)
   );

   typedef struct {
      logic [DW-1:0] d;
      logic [KW-1:0] k;
      logic          l;
   } beat_t;

   beat_t tx_q [REQ_NUM][$];
   beat_t exp_q [$];
   int    total = 0;
   int    bad = 0;
   int    gap_pct = 0;
   int    mr_mode = 0;
   int    mr_phase = 0;
   int    ptr = REQ_NUM - 1;
   int    occ = 0;
   int    pat [6] = '{1, 0, 0, 1, 0, 1};
   bit    have_prev = 0;
   logic [REQ_NUM-1:0] prev_grant, prev_valid, fire;
   logic  prev_link, prev_last_fire;

   // Round-robin rule: first valid index at ptr+1, ptr+2, ... modulo REQ_NUM
   function automatic int rr_pick(logic [REQ_NUM-1:0] v, int p);
      int idx;
      for (int s = 1; s <= REQ_NUM; s++) begin
         idx = (p + s) % REQ_NUM;
         if (v[idx]) return idx;
      end
      return -1;
   endfunction

   function automatic bit drained();
      for (int k = 0; k < REQ_NUM; k++) if (tx_q[k].size() != 0) return 1'b0;
      return (exp_q.size() == 0) && (o_grant == '0) && !m_axis_valid;
   endfunction

   task automatic push_pkt(input int r, input int n, input bit fixed_keep, input logic [KW-1:0] kv);
      beat_t b;
      for (int i = 0; i < n; i++) begin
         b.d = {$urandom, $urandom};
         b.k = fixed_keep ? kv : KW'($urandom_range(1, 255));
         b.l = (i == n - 1);
         tx_q[r].push_back(b);
      end
   endtask

   task automatic clear_model();
      for (int k = 0; k < REQ_NUM; k++) tx_q[k].delete();
      exp_q.delete();
      ptr = REQ_NUM - 1;
   endtask

   task automatic do_reset();
      @(posedge i_clk); #3;
      i_rst_n = 1'b0;
      clear_model();
      repeat (3) @(posedge i_clk);
      #3 i_rst_n = 1'b1;
   endtask

   // Source drivers, grant model and output scoreboard, running every cycle
   initial begin : monitor
      logic [REQ_NUM-1:0] exp_g;
      int    w;
      beat_t b;
      forever begin
         @(negedge i_clk);
         fire = '0;
         w = -1;
         if (!i_rst_n) begin
            have_prev = 0;
            occ = 0;
         end else begin
            total++;
            if ((s_axis_ready & ~o_grant) !== '0) begin
               bad++; $display("FAIL ready_leak: ready=%b grant=%b", s_axis_ready, o_grant);
            end
            total++;
            if (o_busy !== (o_grant != '0)) begin
               bad++; $display("FAIL busy_vs_grant: busy=%b grant=%b", o_busy, o_grant);
            end
            if (have_prev) begin
               exp_g = '0;
               if (prev_grant == '0) begin
                  if (prev_link && prev_valid != '0) begin
                     w = rr_pick(prev_valid, ptr);
                     exp_g[w] = 1'b1;
                  end
               end else if (!prev_last_fire) begin
                  exp_g = prev_grant;
               end
               total++;
               if (o_grant !== exp_g) begin
                  bad++; $display("FAIL grant_model: got=%b exp=%b ptr=%0d", o_grant, exp_g, ptr);
               end
               if (w >= 0) ptr = w;
            end
            if (occ >= 2) begin
               total++;
               if (s_axis_ready !== '0) begin
                  bad++; $display("FAIL skid_full_ready: ready=%b occ=%0d", s_axis_ready, occ);
               end
            end
            if (m_axis_valid && m_axis_ready) begin
               total++;
               if (exp_q.size() == 0) begin
                  bad++; $display("FAIL unexpected_beat: data=%h", m_axis_data);
               end else begin
                  b = exp_q.pop_front();
                  if ({m_axis_data, m_axis_keep, m_axis_last} !== {b.d, b.k, b.l}) begin
                     bad++;
                     $display("FAIL beat: got=%h/%h/%b exp=%h/%h/%b",
                              m_axis_data, m_axis_keep, m_axis_last, b.d, b.k, b.l);
                  end
               end
               occ--;
            end
            fire = s_axis_valid & s_axis_ready;
            prev_last_fire = 1'b0;
            for (int k = 0; k < REQ_NUM; k++) begin
               if (fire[k] && tx_q[k].size() > 0) begin
                  exp_q.push_back(tx_q[k][0]);
                  occ++;
                  prev_last_fire = tx_q[k][0].l;
               end
            end
            prev_grant = o_grant;
            prev_valid = s_axis_valid;
            prev_link  = i_link_up;
            have_prev  = 1;
         end
         @(posedge i_clk); #1;
         for (int k = 0; k < REQ_NUM; k++) begin
            if (fire[k] && tx_q[k].size() > 0) void'(tx_q[k].pop_front());
            if (tx_q[k].size() > 0 && $urandom_range(99) >= gap_pct) begin
               s_axis_valid[k]           = 1'b1;
               s_axis_data[k*DW +: DW]   = tx_q[k][0].d;
               s_axis_keep[k*KW +: KW]   = tx_q[k][0].k;
               s_axis_last[k]            = tx_q[k][0].l;
            end else begin
               s_axis_valid[k] = 1'b0;
            end
         end
         case (mr_mode)
            0:       m_axis_ready = 1'b1;
            1:       m_axis_ready = 1'($urandom_range(1));
            2:       m_axis_ready = 1'b0;
            default: begin m_axis_ready = 1'(pat[mr_phase % 6]); mr_phase++; end
         endcase
      end
   end

   task automatic test_reset();
      repeat (3) @(negedge i_clk);
      total++; if (o_grant !== '0)      begin bad++; $display("FAIL rst_grant: got=%b exp=0", o_grant); end
      total++; if (o_busy !== 1'b0)     begin bad++; $display("FAIL rst_busy: got=%b exp=0", o_busy); end
      total++; if (m_axis_valid !== 1'b0) begin bad++; $display("FAIL rst_mvalid: got=%b exp=0", m_axis_valid); end
      total++; if (s_axis_ready !== '0) begin bad++; $display("FAIL rst_sready: got=%b exp=0", s_axis_ready); end
      total++; if ({m_axis_data, m_axis_keep, m_axis_last} !== '0) begin
         bad++; $display("FAIL rst_mpayload: got=%h/%h/%b exp=0", m_axis_data, m_axis_keep, m_axis_last);
      end
      @(posedge i_clk); #3 i_rst_n = 1'b1;
   endtask

   task automatic test_single_req();
      int c, beats;
      logic prev_acc;
      @(posedge i_clk); #3;
      push_pkt(2, 3, 0, '0);
      c = 0;
      do begin @(negedge i_clk); c++; end while (!s_axis_valid[2] && c < 10);
      @(negedge i_clk);
      total++; if (o_grant !== 4'b0100) begin bad++; $display("FAIL t1_grant: got=%b exp=0100", o_grant); end
      prev_acc = s_axis_valid[2] & s_axis_ready[2];
      beats = 0;
      for (int i = 0; i < 6; i++) begin
         @(negedge i_clk);
         total++;
         if (m_axis_valid !== prev_acc) begin
            bad++; $display("FAIL t1_latency: m_valid=%b exp=%b cyc=%0d", m_axis_valid, prev_acc, i);
         end
         if (m_axis_valid) beats++;
         prev_acc = s_axis_valid[2] & s_axis_ready[2];
      end
      total++; if (beats !== 3) begin bad++; $display("FAIL t1_beats: got=%0d exp=3", beats); end
      total++; if (o_grant !== '0) begin bad++; $display("FAIL t1_release: got=%b exp=0", o_grant); end
   endtask

   task automatic test_round_robin();
      int seq [$];
      int first, last_c, on_cnt;
      logic [REQ_NUM-1:0] pg;
      do_reset();
      for (int k = 0; k < REQ_NUM; k++) begin
         push_pkt(k, 2, 0, '0);
         push_pkt(k, 2, 0, '0);
      end
      first = -1; last_c = -1; on_cnt = 0; pg = '0;
      for (int c = 0; c < 80 && !drained(); c++) begin
         @(negedge i_clk);
         if (o_grant != '0) begin
            if (first < 0) first = c;
            last_c = c;
            on_cnt++;
            if (pg == '0) begin
               for (int k = 0; k < REQ_NUM; k++) if (o_grant[k]) seq.push_back(k);
            end
         end
         pg = o_grant;
      end
      total++; if (seq.size() !== 8) begin bad++; $display("FAIL t2_count: got=%0d exp=8", seq.size()); end
      for (int i = 0; i < seq.size() && i < 8; i++) begin
         total++;
         if (seq[i] !== i % REQ_NUM) begin bad++; $display("FAIL t2_order: pos=%0d got=%0d exp=%0d", i, seq[i], i % REQ_NUM); end
      end
      total++; if (on_cnt !== 16) begin bad++; $display("FAIL t2_grant_cycles: got=%0d exp=16", on_cnt); end
      total++; if (last_c - first !== 22) begin bad++; $display("FAIL t2_span: got=%0d exp=22", last_c - first); end
   endtask

   task automatic test_backpressure();
      int acc;
      @(posedge i_clk); #3;
      mr_mode = 2;
      push_pkt(1, 5, 0, '0);
      acc = 0;
      for (int c = 0; c < 12; c++) begin
         @(negedge i_clk);
         if (s_axis_valid[1] & s_axis_ready[1]) acc++;
      end
      total++; if (acc !== 2) begin bad++; $display("FAIL t3_accepted: got=%0d exp=2", acc); end
      total++; if (s_axis_ready[1] !== 1'b0) begin bad++; $display("FAIL t3_ready: got=%b exp=0", s_axis_ready[1]); end
      total++; if (m_axis_valid !== 1'b1) begin bad++; $display("FAIL t3_mvalid: got=%b exp=1", m_axis_valid); end
      total++; if (o_grant !== 4'b0010) begin bad++; $display("FAIL t3_hold: got=%b exp=0010", o_grant); end
      @(posedge i_clk); #3;
      mr_phase = 0;
      mr_mode = 3;
      for (int c = 0; c < 80 && !drained(); c++) @(posedge i_clk);
      total++; if (!drained()) begin bad++; $display("FAIL t3_drain: left=%0d exp=0", tx_q[1].size() + exp_q.size()); end
      mr_mode = 0;
   endtask

   task automatic test_link();
      int lastcnt, stray;
      @(posedge i_clk); #3;
      i_link_up = 1'b0;
      push_pkt(0, 3, 0, '0);
      for (int c = 0; c < 6; c++) begin
         @(negedge i_clk);
         total++; if (o_grant !== '0) begin bad++; $display("FAIL t4_nogrant: got=%b exp=0", o_grant); end
         total++; if (s_axis_ready !== '0) begin bad++; $display("FAIL t4_noready: got=%b exp=0", s_axis_ready); end
      end
      @(posedge i_clk); #3 i_link_up = 1'b1;
      @(negedge i_clk);
      @(negedge i_clk);
      total++; if (o_grant !== 4'b0001) begin bad++; $display("FAIL t4_grant: got=%b exp=0001", o_grant); end
      @(posedge i_clk); #3;
      i_link_up = 1'b0;
      push_pkt(1, 2, 0, '0);
      lastcnt = 0; stray = 0;
      for (int c = 0; c < 12; c++) begin
         @(negedge i_clk);
         if (m_axis_valid && m_axis_ready && m_axis_last) lastcnt++;
         if (o_grant != '0 && o_grant != 4'b0001) stray++;
      end
      total++; if (tx_q[0].size() !== 0) begin bad++; $display("FAIL t4_complete: left=%0d exp=0", tx_q[0].size()); end
      total++; if (lastcnt !== 1) begin bad++; $display("FAIL t4_last: got=%0d exp=1", lastcnt); end
      total++; if (stray !== 0) begin bad++; $display("FAIL t4_stray_grant: got=%0d exp=0", stray); end
      total++; if (o_grant !== '0) begin bad++; $display("FAIL t4_idle: got=%b exp=0", o_grant); end
      @(posedge i_clk); #3 i_link_up = 1'b1;
      for (int c = 0; c < 40 && !drained(); c++) @(posedge i_clk);
      total++; if (!drained()) begin bad++; $display("FAIL t4_drain: left=%0d exp=0", tx_q[1].size()); end
   endtask

   task automatic test_single_beat();
      int cnt, first, last_c;
      @(posedge i_clk); #3;
      for (int i = 0; i < 6; i++) push_pkt(3, 1, 1, 8'h0F);
      cnt = 0; first = -1; last_c = -1;
      for (int c = 0; c < 40 && !drained(); c++) begin
         @(negedge i_clk);
         if (m_axis_valid) begin
            if (first < 0) first = c;
            last_c = c;
            cnt++;
            total++; if (m_axis_keep !== 8'h0F) begin bad++; $display("FAIL t5_keep: got=%h exp=0f", m_axis_keep); end
            total++; if (m_axis_last !== 1'b1) begin bad++; $display("FAIL t5_last: got=%b exp=1", m_axis_last); end
         end
      end
      total++; if (cnt !== 6) begin bad++; $display("FAIL t5_count: got=%0d exp=6", cnt); end
      total++; if (last_c - first !== 10) begin bad++; $display("FAIL t5_rate: span=%0d exp=10", last_c - first); end
   endtask

   task automatic test_reset_mid();
      int c;
      @(posedge i_clk); #3;
      push_pkt(0, 1, 0, '0);
      for (c = 0; c < 20 && !drained(); c++) @(posedge i_clk);
      @(posedge i_clk); #3;
      push_pkt(2, 4, 0, '0);
      c = 0;
      do begin @(negedge i_clk); c++; end while (!(s_axis_valid[2] && s_axis_ready[2]) && c < 20);
      @(posedge i_clk); #3;
      i_rst_n = 1'b0;
      clear_model();
      #1;
      total++; if (o_grant !== '0)        begin bad++; $display("FAIL t6_grant: got=%b exp=0", o_grant); end
      total++; if (o_busy !== 1'b0)       begin bad++; $display("FAIL t6_busy: got=%b exp=0", o_busy); end
      total++; if (m_axis_valid !== 1'b0) begin bad++; $display("FAIL t6_mvalid: got=%b exp=0", m_axis_valid); end
      total++; if (s_axis_ready !== '0)   begin bad++; $display("FAIL t6_sready: got=%b exp=0", s_axis_ready); end
      total++; if ({m_axis_data, m_axis_keep, m_axis_last} !== '0) begin
         bad++; $display("FAIL t6_payload: got=%h/%h/%b exp=0", m_axis_data, m_axis_keep, m_axis_last);
      end
      repeat (3) @(posedge i_clk);
      #3 i_rst_n = 1'b1;
      push_pkt(0, 2, 0, '0);
      push_pkt(2, 4, 0, '0);
      c = 0;
      do begin @(negedge i_clk); c++; end while (o_grant == '0 && c < 10);
      total++; if (o_grant !== 4'b0001) begin bad++; $display("FAIL t6_priority: got=%b exp=0001", o_grant); end
      for (c = 0; c < 40 && !drained(); c++) @(posedge i_clk);
      total++; if (!drained()) begin bad++; $display("FAIL t6_drain: left=%0d exp=0", exp_q.size()); end
   endtask

   task automatic test_random();
      @(posedge i_clk); #3;
      gap_pct = 25;
      mr_mode = 1;
      for (int c = 0; c < 500; c++) begin
         @(posedge i_clk); #3;
         if ($urandom_range(99) < 15) push_pkt($urandom_range(REQ_NUM - 1), $urandom_range(1, 6), 0, '0);
         if ($urandom_range(99) < 3) i_link_up = ~i_link_up;
      end
      i_link_up = 1'b1;
      gap_pct = 0;
      mr_mode = 0;
      for (int c = 0; c < 1500 && !drained(); c++) @(posedge i_clk);
      total++; if (!drained()) begin bad++; $display("FAIL rnd_drain: left=%0d exp=0", exp_q.size()); end
   endtask

   initial begin : main
      i_rst_n      = 1'b0;
      i_link_up    = 1'b1;
      m_axis_ready = 1'b1;
      s_axis_valid = '0;
      s_axis_data  = '0;
      s_axis_keep  = '0;
      s_axis_last  = '0;
      test_reset();
      test_single_req();
      test_round_robin();
      test_backpressure();
      test_link();
      test_single_beat();
      test_reset_mid();
      test_random();
      repeat (3) @(posedge i_clk);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
